// File: rtl/zero_byte_frame_acc.sv
// Per-frame accumulator for zero-byte counts: total, word count and first-hit index.
// Results are published through a single-entry valid/ready output register.
module zero_byte_frame_acc #(
  parameter int unsigned IDX_W = 16,
  parameter int unsigned TOT_W = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_count,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TOT_W-1:0] out_total,
  output logic [IDX_W-1:0] out_words,
  output logic             out_found,
  output logic [IDX_W-1:0] out_first_idx,
  output logic             out_err
);

  localparam int unsigned SUM_W = TOT_W + 1;
  localparam logic [IDX_W-1:0] IDX_MAX = '1;
  localparam logic [TOT_W-1:0] TOT_MAX = '1;

  typedef enum logic {IDLE, ACC} state_e;

  state_e           state_q, state_d;
  logic [TOT_W-1:0] tot_q, tot_d;
  logic [IDX_W-1:0] words_q, words_d;
  logic [IDX_W-1:0] first_q, first_d;
  logic             found_q, found_d;
  logic             err_q, err_d;

  logic             out_valid_q, out_valid_d;
  logic [TOT_W-1:0] out_total_q, out_total_d;
  logic [IDX_W-1:0] out_words_q, out_words_d;
  logic             out_found_q, out_found_d;
  logic [IDX_W-1:0] out_first_q, out_first_d;
  logic             out_err_q, out_err_d;

  logic             accept;
  logic [2:0]       cnt;
  logic [2:0]       c;
  logic             illegal;
  logic             first_beat;
  logic [TOT_W-1:0] base_tot;
  logic [IDX_W-1:0] base_words;
  logic [IDX_W-1:0] base_first;
  logic             base_found;
  logic             base_err;
  logic [SUM_W-1:0] tot_sum;
  logic             tot_sat;
  logic             words_sat;
  logic [TOT_W-1:0] beat_tot;
  logic [IDX_W-1:0] beat_words;
  logic [IDX_W-1:0] beat_first;
  logic             beat_found;
  logic             beat_err;

  // Backpressure depends only on the output register, never on in_valid
  assign in_ready = rst_n & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  // Beat contribution; the first beat of a frame starts from zero instead of the accumulators
  always_comb begin
    cnt        = in_valid ? in_count : 3'd0;
    illegal    = cnt > 3'd4;
    c          = illegal ? 3'd4 : cnt;
    first_beat = (state_q == IDLE);

    base_tot   = first_beat ? '0   : tot_q;
    base_words = first_beat ? '0   : words_q;
    base_first = first_beat ? '0   : first_q;
    base_found = first_beat ? 1'b0 : found_q;
    base_err   = first_beat ? 1'b0 : err_q;

    tot_sum    = SUM_W'(base_tot) + SUM_W'(c);
    tot_sat    = tot_sum[TOT_W];
    beat_tot   = tot_sat ? TOT_MAX : tot_sum[TOT_W-1:0];

    words_sat  = (base_words == IDX_MAX);
    beat_words = words_sat ? IDX_MAX : base_words + IDX_W'(1);

    beat_found = base_found | (c != 3'd0);
    beat_first = ((c != 3'd0) && !base_found) ? base_words : base_first;
    beat_err   = base_err | illegal | tot_sat | words_sat;
  end

  // Next-state: accumulate, publish on last beat, retire result on transfer
  always_comb begin
    state_d     = state_q;
    tot_d       = tot_q;
    words_d     = words_q;
    first_d     = first_q;
    found_d     = found_q;
    err_d       = err_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_total_d = out_total_q;
    out_words_d = out_words_q;
    out_found_d = out_found_q;
    out_first_d = out_first_q;
    out_err_d   = out_err_q;

    if (accept) begin
      tot_d   = beat_tot;
      words_d = beat_words;
      first_d = beat_first;
      found_d = beat_found;
      err_d   = beat_err;
      if (in_last) begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
        out_total_d = beat_tot;
        out_words_d = beat_words;
        out_found_d = beat_found;
        out_first_d = beat_first;
        out_err_d   = beat_err;
      end else begin
        state_d = ACC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tot_q       <= '0;
      words_q     <= '0;
      first_q     <= '0;
      found_q     <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_total_q <= '0;
      out_words_q <= '0;
      out_found_q <= 1'b0;
      out_first_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tot_q       <= tot_d;
      words_q     <= words_d;
      first_q     <= first_d;
      found_q     <= found_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_total_q <= out_total_d;
      out_words_q <= out_words_d;
      out_found_q <= out_found_d;
      out_first_q <= out_first_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_total     = out_total_q;
  assign out_words     = out_words_q;
  assign out_found     = out_found_q;
  assign out_first_idx = out_first_q;
  assign out_err       = out_err_q;

endmodule

// File: tb/tb_zero_byte_frame_acc.sv
// Scoreboard bench for zero_byte_frame_acc: default build plus an IDX_W=2 build on shared inputs.
module tb_zero_byte_frame_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_count;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_total;
  logic [15:0] out_words;
  logic        out_found;
  logic [15:0] out_first_idx;
  logic        out_err;

  logic        b_in_ready;
  logic        b_out_valid;
  logic [17:0] b_out_total;
  logic [1:0]  b_out_words;
  logic        b_out_found;
  logic [1:0]  b_out_first_idx;
  logic        b_out_err;

  typedef struct {
    logic [17:0] total;
    logic [15:0] words;
    logic        found;
    logic [15:0] first;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_xfer = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  zero_byte_frame_acc #(.IDX_W(16), .TOT_W(18)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_count(in_count), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_total(out_total), .out_words(out_words), .out_found(out_found),
    .out_first_idx(out_first_idx), .out_err(out_err)
  );

  zero_byte_frame_acc #(.IDX_W(2), .TOT_W(18)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_count(in_count), .in_last(in_last), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_total(b_out_total), .out_words(b_out_words), .out_found(b_out_found),
    .out_first_idx(b_out_first_idx), .out_err(b_out_err)
  );

  // Scoreboard: every transfer on the default build pops and compares one expected result
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got total=%0d words=%0d found=%0d first=%0d err=%0d with empty scoreboard",
                 out_total, out_words, out_found, out_first_idx, out_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({out_total, out_words, out_found, out_first_idx, out_err} !==
            {e.total, e.words, e.found, e.first, e.err}) begin
          errors++;
          $display("FAIL result: got total=%0d words=%0d found=%0d first=%0d err=%0d, expected total=%0d words=%0d found=%0d first=%0d err=%0d",
                   out_total, out_words, out_found, out_first_idx, out_err,
                   e.total, e.words, e.found, e.first, e.err);
        end
      end
      n_xfer++;
    end
  end

  task automatic push(input int t, input int w, input bit f, input int i, input bit e);
    exp_t x;
    x.total = 18'(t);
    x.words = 16'(w);
    x.found = f;
    x.first = 16'(i);
    x.err   = e;
    sb.push_back(x);
  endtask

  // One beat, held until accepted; inputs go to X once the beat is gone
  task automatic beat(input logic [2:0] cnt, input logic last);
    bit acc;
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_count = cnt;
    in_last  = last;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL beat_stall: in_ready stayed %0b for %0d cycles, expected 1", in_ready, n);
    end
    in_valid = 1'b0;
    in_count = 3'bxxx;
    in_last  = 1'bx;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d results still pending, expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_count  = 3'bxxx;
    in_last   = 1'bx;
    out_ready = 1'b1;
    #3;
    checks++;
    if ({out_valid, out_total, out_words, out_found, out_first_idx, out_err} !== 54'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b total=%0d words=%0d found=%0b first=%0d err=%0b, expected all 0",
               out_valid, out_total, out_words, out_found, out_first_idx, out_err);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b, expected 0", in_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_in_ready: got %0b, expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    push(4, 4, 1'b1, 2, 1'b0);
    beat(3'd0, 1'b0);
    beat(3'd0, 1'b0);
    beat(3'd3, 1'b0);
    beat(3'd1, 1'b1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: out_valid=%0b one cycle after last beat, expected 1", out_valid);
    end
    wait_drain("basic");
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    push(0, 3, 1'b0, 0, 1'b0);
    beat(3'd0, 1'b0);
    beat(3'd0, 1'b0);
    beat(3'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, out_total, out_words, out_found, out_first_idx, out_err} !==
          {1'b1, 1'b0, 18'd0, 16'd3, 1'b0, 16'd0, 1'b0}) begin
        errors++;
        $display("FAIL hold_cycle%0d: got valid=%0b in_ready=%0b total=%0d words=%0d found=%0b first=%0d, expected 1 0 0 3 0 0",
                 i, out_valid, in_ready, out_total, out_words, out_found, out_first_idx);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("hold");
  endtask

  task automatic test_back_to_back();
    int t0;
    int x0;
    push(4, 1, 1'b1, 0, 1'b0);
    push(2, 1, 1'b1, 0, 1'b0);
    push(0, 1, 1'b0, 0, 1'b0);
    t0 = cyc;
    x0 = n_xfer;
    beat(3'd4, 1'b1);
    beat(3'd2, 1'b1);
    beat(3'd0, 1'b1);
    checks++;
    if (cyc - t0 != 3 || n_xfer - x0 != 2) begin
      errors++;
      $display("FAIL b2b_rate: took %0d cycles with %0d transfers, expected 3 cycles and 2 transfers",
               cyc - t0, n_xfer - x0);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_third_valid: got %0b, expected 1", out_valid);
    end
    wait_drain("b2b");
  endtask

  task automatic test_err();
    push(5, 2, 1'b1, 0, 1'b1);
    beat(3'd7, 1'b0);
    beat(3'd1, 1'b1);
    push(1, 1, 1'b1, 0, 1'b0);
    beat(3'd1, 1'b1);
    wait_drain("err");
  endtask

  task automatic test_saturation();
    push(0, 5, 1'b0, 0, 1'b0);
    for (int i = 0; i < 5; i++) beat(3'd0, i == 4);
    @(negedge clk);
    checks++;
    if ({b_out_valid, b_out_words, b_out_err, b_out_total, b_out_found} !==
        {1'b1, 2'd3, 1'b1, 18'd0, 1'b0}) begin
      errors++;
      $display("FAIL idx2_saturation: got valid=%0b words=%0d err=%0b total=%0d found=%0b, expected 1 3 1 0 0",
               b_out_valid, b_out_words, b_out_err, b_out_total, b_out_found);
    end
    wait_drain("sat");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    beat(3'd3, 1'b1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pending_before_reset: out_valid=%0b, expected 1", out_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_drops_pending: valid=%0b in_ready=%0b, expected 0 0", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    beat(3'd1, 1'b0);
    beat(3'd1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(2, 1, 1'b1, 0, 1'b0);
    beat(3'd2, 1'b1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_words !== 16'd1 || out_total !== 18'd2) begin
      errors++;
      $display("FAIL reset_mid_frame: valid=%0b words=%0d total=%0d, expected 1 1 2", out_valid, out_words, out_total);
    end
    wait_drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_back_to_back();
    test_err();
    test_saturation();
    test_reset_mid();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL final_idle: pending=%0d out_valid=%0b, expected 0 0", sb.size(), out_valid);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
